// File: rtl/mips_pkg.sv
// Shared widths, FSM state encoding and writeback payload type for the
// register-file writeback arbiter.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        NORMAL   = 1'b0,
        B_FORCED = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the scoreboard view and
// the register-file write port.
interface regfile_wb_arbiter_if;
    import mips_pkg::*;

    logic                  a_valid;
    logic                  a_regrt;
    logic [REG_ADDR_W-1:0] a_rd;
    logic [REG_ADDR_W-1:0] a_rt;
    logic [DATA_W-1:0]     a_data;
    logic                  a_stall;
    logic                  b_valid;
    logic [REG_ADDR_W-1:0] b_dest;
    logic [DATA_W-1:0]     b_data;
    logic                  b_ready;
    logic                  b_issue;
    logic [REG_ADDR_W-1:0] b_issue_dest;
    logic [NUM_REGS-1:0]   busy;
    logic                  we;
    logic [REG_ADDR_W-1:0] wn;
    logic [DATA_W-1:0]     wd;

    modport master (
        output a_valid, a_regrt, a_rd, a_rt, a_data,
        output b_valid, b_dest, b_data, b_issue, b_issue_dest,
        input  a_stall, b_ready, busy, we, wn, wd
    );

    modport slave (
        input  a_valid, a_regrt, a_rd, a_rt, a_data,
        input  b_valid, b_dest, b_data, b_issue, b_issue_dest,
        output a_stall, b_ready, busy, we, wn, wd
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard: set on mul/div issue, clear on
// accepted B writeback; set wins on collision, register 0 never busy.
module wb_scoreboard
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates pipeline (A) and mul/div (B) writebacks onto one register-file
// write port. Starvation guard for B is enabled by WB_STARVE_GUARD_EN.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 clrn,
    regfile_wb_arbiter_if.slave bus
);

    logic    grant_a;
    logic    grant_b;
    logic    stall;
    wb_req_t a_req;
    wb_req_t b_req;
    wb_req_t win;

    logic                  we_q;
    logic [REG_ADDR_W-1:0] wn_q;
    logic [DATA_W-1:0]     wd_q;
    logic [NUM_REGS-1:0]   busy;

    // Requester payloads and winner select
    always_comb begin
        a_req.dest = bus.a_regrt ? bus.a_rt : bus.a_rd;
        a_req.data = bus.a_data;
        b_req.dest = bus.b_dest;
        b_req.data = bus.b_data;
        win        = grant_a ? a_req : b_req;
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    wb_state_e        state_q;
    wb_state_e        state_d;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Grant, B wait counting and forced-B transitions
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        stall   = 1'b0;

        case (state_q)
            NORMAL: begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid & ~bus.a_valid;
                if (bus.b_valid && (wait_q == CNT_W'(STARVE_LIMIT))) state_d = B_FORCED;
            end
            B_FORCED: begin
                grant_b = bus.b_valid;
                stall   = bus.a_valid;
                if (grant_b || !bus.b_valid) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase

        if (bus.b_valid && !grant_b) begin
            if (wait_q != CNT_W'(STARVE_LIMIT)) wait_d = wait_q + 1'b1;
        end else begin
            wait_d = '0;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT;

    // Strict A priority
    always_comb begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid & ~bus.a_valid;
        stall   = 1'b0;
    end
`endif

    // Registered write port; register 0 is accepted but never written
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we_q <= 1'b0;
            wn_q <= '0;
            wd_q <= '0;
        end else if (grant_a || grant_b) begin
            we_q <= (win.dest != '0);
            wn_q <= win.dest;
            wd_q <= win.data;
        end else begin
            we_q <= 1'b0;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk     (clk),
        .clrn    (clrn),
        .set_en  (bus.b_issue),
        .set_idx (bus.b_issue_dest),
        .clr_en  (grant_b),
        .clr_idx (bus.b_dest),
        .busy    (busy)
    );

    assign bus.a_stall = stall & clrn;
    assign bus.b_ready = grant_b & clrn;
    assign bus.busy    = busy;
    assign bus.we      = we_q;
    assign bus.wn      = wn_q;
    assign bus.wd      = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural
// model; build with WB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic clrn;
    int   total;
    int   bad;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference state
    logic        m_we;
    logic [4:0]  m_wn;
    logic [31:0] m_wd;
    logic [31:0] m_busy;
    int          m_wait;
    bit          m_forced;

    function automatic void model_reset();
        m_we = 1'b0; m_wn = '0; m_wd = '0; m_busy = '0;
        m_wait = 0; m_forced = 1'b0;
    endfunction

    function automatic void model_grant(output bit ga, output bit gb, output bit st);
        ga = 1'b0; gb = 1'b0; st = 1'b0;
        if (clrn !== 1'b1) return;
        if (m_forced) begin
            gb = bus.b_valid;
            st = bus.a_valid;
        end else begin
            ga = bus.a_valid;
            gb = bus.b_valid && !bus.a_valid;
        end
    endfunction

    function automatic void model_seq();
        bit ga, gb, st;
        logic [4:0]  dest;
        logic [31:0] data;
        model_grant(ga, gb, st);
        if (ga || gb) begin
            dest = ga ? (bus.a_regrt ? bus.a_rt : bus.a_rd) : bus.b_dest;
            data = ga ? bus.a_data : bus.b_data;
            m_we = (dest != 5'd0);
            m_wn = dest;
            m_wd = data;
        end else begin
            m_we = 1'b0;
        end
        if (gb) m_busy[bus.b_dest] = 1'b0;
        if (bus.b_issue && bus.b_issue_dest != 5'd0) m_busy[bus.b_issue_dest] = 1'b1;
`ifdef WB_STARVE_GUARD_EN
        if (m_forced) m_forced = !(gb || !bus.b_valid);
        else          m_forced = (m_wait == LIMIT) && bus.b_valid;
        if (bus.b_valid && !gb) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
        else                    m_wait = 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 0; bus.a_regrt = 0; bus.a_rd = '0; bus.a_rt = '0; bus.a_data = '0;
        bus.b_valid = 0; bus.b_dest = '0; bus.b_data = '0;
        bus.b_issue = 0; bus.b_issue_dest = '0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        idle_inputs();
        model_reset();
        bus.a_valid = 1; bus.b_valid = 1; bus.b_dest = 5'd3;
        #2;
        total++;
        if (bus.b_ready !== 1'b0 || bus.a_stall !== 1'b0) begin
            bad++; $display("FAIL reset_hs: b_ready=%b a_stall=%b expected 0 0", bus.b_ready, bus.a_stall);
        end
        total++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd0 || bus.wd !== 32'd0 || bus.busy !== 32'd0) begin
            bad++; $display("FAIL reset_out: we=%b wn=%0d wd=%h busy=%h expected all 0", bus.we, bus.wn, bus.wd, bus.busy);
        end
        idle_inputs();
        #10 clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_a_write();
        bus.a_valid = 1; bus.a_regrt = 1; bus.a_rt = 5'd9; bus.a_rd = 5'd4; bus.a_data = 32'h1234;
        #1;
        total++;
        if (bus.a_stall !== 1'b0) begin bad++; $display("FAIL a_stall: got %b expected 0", bus.a_stall); end
        step();
        total++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd9 || bus.wd !== 32'h1234) begin
            bad++; $display("FAIL a_rt_write: we=%b wn=%0d wd=%h expected 1 9 1234", bus.we, bus.wn, bus.wd);
        end
        bus.a_regrt = 0; bus.a_data = 32'h55;
        step();
        total++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd4 || bus.wd !== 32'h55) begin
            bad++; $display("FAIL a_rd_write: we=%b wn=%0d wd=%h expected 1 4 55", bus.we, bus.wn, bus.wd);
        end
        bus.a_valid = 0;
    endtask

    task automatic test_b_write();
        bus.b_issue = 1; bus.b_issue_dest = 5'd12;
        step();
        bus.b_issue = 0;
        total++;
        if (bus.busy[12] !== 1'b1) begin bad++; $display("FAIL busy_set: got %b expected 1", bus.busy[12]); end
        bus.b_valid = 1; bus.b_dest = 5'd12; bus.b_data = 32'hCAFE;
        #1;
        total++;
        if (bus.b_ready !== 1'b1) begin bad++; $display("FAIL b_ready: got %b expected 1", bus.b_ready); end
        step();
        bus.b_valid = 0;
        total++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd12 || bus.wd !== 32'hCAFE || bus.busy[12] !== 1'b0) begin
            bad++; $display("FAIL b_write: we=%b wn=%0d wd=%h busy12=%b expected 1 12 cafe 0",
                            bus.we, bus.wn, bus.wd, bus.busy[12]);
        end
    endtask

    task automatic test_hold();
        step();
        total++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd12 || bus.wd !== 32'hCAFE) begin
            bad++; $display("FAIL idle_hold: we=%b wn=%0d wd=%h expected 0 12 cafe", bus.we, bus.wn, bus.wd);
        end
    endtask

    task automatic test_zero_dest();
        bus.a_valid = 1; bus.a_regrt = 0; bus.a_rd = 5'd0; bus.a_data = 32'hDEAD;
        step();
        bus.a_valid = 0;
        total++;
        if (bus.we !== 1'b0) begin bad++; $display("FAIL a_zero: we=%b expected 0", bus.we); end
        bus.b_valid = 1; bus.b_dest = 5'd0; bus.b_data = 32'hBEEF;
        #1;
        total++;
        if (bus.b_ready !== 1'b1) begin bad++; $display("FAIL b_zero_ready: got %b expected 1", bus.b_ready); end
        step();
        bus.b_valid = 0;
        total++;
        if (bus.we !== 1'b0) begin bad++; $display("FAIL b_zero_we: we=%b expected 0", bus.we); end
    endtask

    task automatic test_busy_collision();
        bus.b_issue = 1; bus.b_issue_dest = 5'd7;
        step();
        bus.b_valid = 1; bus.b_dest = 5'd7; bus.b_data = 32'h77;
        step();
        bus.b_valid = 0;
        total++;
        if (bus.busy[7] !== 1'b1) begin bad++; $display("FAIL busy_collide: got %b expected 1", bus.busy[7]); end
        bus.b_issue_dest = 5'd0;
        step();
        bus.b_issue = 0;
        total++;
        if (bus.busy[0] !== 1'b0) begin bad++; $display("FAIL busy_zero: got %b expected 0", bus.busy[0]); end
    endtask

    task automatic test_starve();
        idle_inputs();
        step();
        bus.a_valid = 1; bus.a_regrt = 1; bus.a_rt = 5'd2; bus.a_data = 32'hA0;
        bus.b_valid = 1; bus.b_dest = 5'd5; bus.b_data = 32'hB0;
`ifdef WB_STARVE_GUARD_EN
        for (int i = 0; i < LIMIT + 1; i++) begin
            #1;
            total++;
            if (bus.b_ready !== 1'b0 || bus.a_stall !== 1'b0) begin
                bad++; $display("FAIL starve_wait c%0d: b_ready=%b a_stall=%b expected 0 0", i, bus.b_ready, bus.a_stall);
            end
            step();
        end
        #1;
        total++;
        if (bus.b_ready !== 1'b1 || bus.a_stall !== 1'b1) begin
            bad++; $display("FAIL starve_force: b_ready=%b a_stall=%b expected 1 1", bus.b_ready, bus.a_stall);
        end
        step();
        bus.b_valid = 0;
        #1;
        total++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd5 || bus.a_stall !== 1'b0) begin
            bad++; $display("FAIL starve_after: we=%b wn=%0d a_stall=%b expected 1 5 0", bus.we, bus.wn, bus.a_stall);
        end
`else
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (bus.b_ready !== 1'b0 || bus.a_stall !== 1'b0) begin
                bad++; $display("FAIL a_priority c%0d: b_ready=%b a_stall=%b expected 0 0", i, bus.b_ready, bus.a_stall);
            end
            step();
        end
`endif
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        bit ga, gb, st, b_pending;
        b_pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.a_valid = ($urandom_range(0, 9) < 6);
            bus.a_regrt = 1'($urandom_range(0, 1));
            bus.a_rd = 5'($urandom_range(0, 7));
            bus.a_rt = 5'($urandom_range(0, 7));
            bus.a_data = $urandom();
            if (!b_pending) begin
                bus.b_valid = 1'($urandom_range(0, 1));
                bus.b_dest = 5'($urandom_range(0, 7));
                bus.b_data = $urandom();
            end
            bus.b_issue = ($urandom_range(0, 3) == 0);
            bus.b_issue_dest = 5'($urandom_range(0, 7));
            #1;
            model_grant(ga, gb, st);
            total++;
            if (bus.b_ready !== gb || bus.a_stall !== st) begin
                bad++; $display("FAIL rnd_hs c%0d: b_ready=%b a_stall=%b expected %b %b", i, bus.b_ready, bus.a_stall, gb, st);
            end
            b_pending = bus.b_valid && !gb;
            step();
            total++;
            if (bus.we !== m_we || bus.wn !== m_wn || bus.wd !== m_wd || bus.busy !== m_busy) begin
                bad++; $display("FAIL rnd_out c%0d: we=%b wn=%0d wd=%h busy=%h expected %b %0d %h %h",
                                i, bus.we, bus.wn, bus.wd, bus.busy, m_we, m_wn, m_wd, m_busy);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        bus.a_valid = 1; bus.a_regrt = 1; bus.a_rt = 5'd6; bus.a_data = 32'h66;
        bus.b_valid = 1; bus.b_dest = 5'd3; bus.b_data = 32'h33;
        bus.b_issue = 1; bus.b_issue_dest = 5'd9;
        for (int i = 0; i < LIMIT + 2; i++) step();
        bus.b_issue = 0;
        #1 clrn = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd0 || bus.wd !== 32'd0 || bus.busy !== 32'd0 ||
            bus.b_ready !== 1'b0 || bus.a_stall !== 1'b0) begin
            bad++; $display("FAIL mid_reset: we=%b wn=%0d wd=%h busy=%h b_ready=%b a_stall=%b expected all 0",
                            bus.we, bus.wn, bus.wd, bus.busy, bus.b_ready, bus.a_stall);
        end
        #2 clrn = 1'b1;
        #1;
        total++;
        if (bus.a_stall !== 1'b0 || bus.b_ready !== 1'b0) begin
            bad++; $display("FAIL post_reset_state: a_stall=%b b_ready=%b expected 0 0", bus.a_stall, bus.b_ready);
        end
        step();
        total++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd6 || bus.wd !== 32'h66) begin
            bad++; $display("FAIL post_reset_write: we=%b wn=%0d wd=%h expected 1 6 66", bus.we, bus.wn, bus.wd);
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_a_write();
        test_b_write();
        test_hold();
        test_zero_dest();
        test_busy_collision();
        test_starve();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive B-wait cycles before B is forced onto the port.
REQ-002 The block SHALL have these ports:
  clk  in  1  sole clock; all state changes on the rising edge
  clrn  in  1  asynchronous active-low reset
  a_valid  in  1  pipeline writeback request (requester A)
  a_regrt  in  1  A destination select: 1 selects a_rt, 0 selects a_rd
  a_rd  in  5  A rd field
  a_rt  in  5  A rt field
  a_data  in  32  A write data
  a_stall  out  1  pipeline must hold its A request this cycle
  b_valid  in  1  mul/div result request (requester B)
  b_dest  in  5  B destination register
  b_data  in  32  B write data
  b_ready  out  1  B request accepted this cycle
  b_issue  in  1  mul/div op issued; mark destination pending
  b_issue_dest  in  5  destination of the issued op
  busy  out  32  per-register pending-B-write scoreboard
  we  out  1  register file write enable (registered)
  wn  out  5  register file write number (registered)
  wd  out  32  register file write data (registered)

Function
REQ-003 The A destination SHALL be a_rt when a_regrt=1, otherwise a_rd.
REQ-004 Grant SHALL be combinational each cycle; at most one requester SHALL be granted per cycle.
REQ-005 In state NORMAL: A granted if a_valid; B granted if b_valid and not a_valid; a_stall=0.
REQ-006 In state B_FORCED: B granted if b_valid; a_stall=a_valid; A not granted.
REQ-007 b_ready SHALL equal B-granted; B SHALL hold b_valid/b_dest/b_data stable until b_ready=1.
REQ-008 The winner's destination/data SHALL appear on wn/wd with we=1 on the clock edge after grant (latency 1).
REQ-009 If no grant occurs, we SHALL be 0 next cycle; wn/wd SHALL hold their previous values.
REQ-010 A granted write to register 0 SHALL produce we=0 but still count as accepted (b_ready=1 for B).
REQ-011 wait_cnt (width ceil(log2(STARVE_LIMIT+1))) SHALL increment, saturating at STARVE_LIMIT, each cycle b_valid=1 and b_ready=0, and clear when b_ready=1 or b_valid=0.
REQ-012 FSM NORMAL->B_FORCED when wait_cnt=STARVE_LIMIT and b_valid=1; B_FORCED->NORMAL on the cycle b_ready=1 or b_valid=0.
REQ-013 busy[n] SHALL set on b_issue with b_issue_dest=n and clear when B is granted with b_dest=n.
REQ-014 Simultaneous set and clear of the same busy bit SHALL leave it set.
REQ-015 busy[0] SHALL be constant 0; b_issue to register 0 SHALL be ignored.
REQ-016 b_valid with b_dest whose busy bit is 0 SHALL still be written (no check); scoreboard is advisory.

Reset
REQ-017 clrn=0 SHALL immediately force we=0, wn=0, wd=0, busy=0, wait_cnt=0, state NORMAL, regardless of clk.
REQ-018 Reset mid-operation SHALL drop any unaccepted B request; B must re-present after clrn=1.
REQ-019 a_stall and b_ready SHALL be 0 while clrn=0.

Configuration
REQ-020 Macro WB_STARVE_GUARD_EN SHALL gate the starvation guard.
REQ-021 With WB_STARVE_GUARD_EN defined: REQ-006, REQ-011 and REQ-012 apply.
REQ-022 Without WB_STARVE_GUARD_EN: no wait_cnt and no FSM, strict A priority, a_stall tied 0; STARVE_LIMIT is unused.

Structure
REQ-023 Shared package mips_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and the FSM state encoding (NORMAL=0, B_FORCED=1).
REQ-024 The scoreboard SHALL be sub-module wb_scoreboard (busy set/clear only); arbitration, FSM and output registers SHALL stay in the top module.

Verification
REQ-025 a_valid=1, a_regrt=1, a_rt=9, a_rd=4, a_data=0x1234, b_valid=0 -> next cycle we=1, wn=9, wd=0x1234.
REQ-026 a_valid=0, b_valid=1, b_dest=12, b_data=0xCAFE -> b_ready=1 same cycle; next cycle we=1, wn=12, wd=0xCAFE, busy[12] cleared.
REQ-027 Guard on, STARVE_LIMIT=4, a_valid and b_valid held high -> b_ready=0 for 5 cycles; 6th cycle a_stall=1 and b_ready=1; following cycle a_stall=0.
REQ-028 b_issue=1, b_issue_dest=7 in the same cycle B is granted with b_dest=7 -> busy[7]=1 afterwards; b_issue_dest=0 -> busy[0]=0.
REQ-029 a_valid=1, a_regrt=0, a_rd=0 -> we=0 next cycle; clrn pulsed low mid-stream -> all outputs 0 immediately, state NORMAL.
REQ-030 Guard off, a_valid high 10 cycles with b_valid high -> b_ready=0 throughout and a_stall=0 throughout.
